counter_arb: RTL and testbench

- Round-robin scheduler that shares one 8-bit up-counter among NREQ requesters.
- Each requester asks for a timed window of len[i] clock cycles.
- The arbiter grants one requester at a time, clears and runs the counter for that window, then pulses done with the winner's id.
- Sits between the counter datapath and the blocks that need timed intervals.

---
 rtl/counter_arb_pkg.sv | 35 +++
 rtl/counter_arb_if.sv | 25 ++
 rtl/counter_en.sv | 27 ++
 rtl/counter_arb.sv | 118 +++++++++++
 tb/tb_counter_arb.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_arb_pkg.sv
// Shared types, default sizes and the round-robin pick for the counter arbiter.
package counter_arb_pkg;

   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_IDW   = 2;
   localparam int unsigned MAX_NREQ  = 8;
   localparam int unsigned MAX_IDW   = 3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // First set bit of req scanning last+1, last+2, ... modulo n; returns last when req is empty.
   function automatic int unsigned rr_winner(input logic [MAX_NREQ-1:0] req,
                                             input int unsigned last,
                                             input int unsigned n);
      int unsigned win;
      int unsigned idx;
      logic [MAX_IDW-1:0] sel;
      win = last;
      // Walk from the farthest candidate down so the nearest hit is written last.
      for (int unsigned i = MAX_NREQ; i >= 1; i--) begin
         idx = (last + i) % n;
         sel = idx[MAX_IDW-1:0];
         if (i <= n && req[sel]) begin
            win = idx;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/counter_arb_if.sv
// Requester-side bus of the counter arbiter: levels and lengths in, grant and timing status out.
interface counter_arb_if #(
   parameter int unsigned NREQ  = counter_arb_pkg::DEF_NREQ,
   parameter int unsigned WIDTH = counter_arb_pkg::DEF_WIDTH,
   parameter int unsigned IDW   = counter_arb_pkg::DEF_IDW
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] len;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [WIDTH-1:0]      value;
   logic                  done;
   logic                  abort;
   logic [IDW-1:0]        done_id;

   modport master (
      output req, len,
      input  grant, busy, value, done, abort, done_id
   );

   modport slave (
      input  req, len,
      output grant, busy, value, done, abort, done_id
   );
endinterface

// File: rtl/counter_en.sv
// Up-counter with synchronous clear and count enable; clear wins over enable.
module counter_en #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_value
);

   logic [WIDTH-1:0] r_value;

   // Counter register: reset and clear to zero, otherwise step when enabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_value <= '0;
      end else if (i_clear) begin
         r_value <= '0;
      end else if (i_enable) begin
         r_value <= r_value + WIDTH'(1);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/counter_arb.sv
// Round-robin owner of one shared up-counter: grants a window of len cycles, then reports done.
module counter_arb
   import counter_arb_pkg::*;
#(
   parameter int unsigned NREQ  = DEF_NREQ,
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned IDW   = DEF_IDW
) (
   input logic          clk,
   input logic          reset,
   counter_arb_if.slave bus
);

   state_e           r_state;
   state_e           w_state_next;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_done_id;
   logic [WIDTH-1:0] r_len;
   logic [NREQ-1:0]  r_grant;
   logic             r_abort;

   logic [IDW-1:0]   w_win;
   logic [NREQ-1:0]  w_onehot;
   logic [WIDTH-1:0] w_len_arr [NREQ];
   logic [WIDTH-1:0] w_len_win;
   logic [WIDTH-1:0] w_value;
   logic             w_any_req;
   logic             w_owner_req;
   logic             w_clear;
   logic             w_enable;
   logic             w_abandon;

   assign w_any_req   = |bus.req;
   assign w_owner_req = bus.req[r_last];
   assign w_win       = IDW'(rr_winner(MAX_NREQ'(bus.req), int'(r_last), NREQ));
   assign w_onehot    = NREQ'(1) << w_win;
   assign w_len_win   = w_len_arr[w_win];

   // Unpack the flat length bus into one entry per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_len_arr[i] = bus.len[i*WIDTH +: WIDTH];
      end
   end

   // Next state plus counter clear/enable; the owner dropping req takes precedence over completion.
   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_enable     = 1'b0;
      w_abandon    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_any_req) begin
               w_clear      = 1'b1;
               w_state_next = (w_len_win == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (!w_owner_req) begin
               w_abandon    = 1'b1;
               w_state_next = StIdle;
            end else if (w_value == r_len - WIDTH'(1)) begin
               w_state_next = StDone;
            end else begin
               w_enable = 1'b1;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // State, pointer, latched length, grant and the abort pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_last    <= IDW'(NREQ - 1);
         r_len     <= '0;
         r_grant   <= '0;
         r_abort   <= 1'b0;
         r_done_id <= '0;
      end else begin
         r_state <= w_state_next;
         r_abort <= w_abandon;
         if (w_clear) begin
            r_grant   <= w_onehot;
            r_last    <= w_win;
            r_len     <= w_len_win;
            r_done_id <= w_win;
         end else if (w_state_next == StIdle) begin
            r_grant <= '0;
         end
      end
   end

   counter_en #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_enable(w_enable),
      .o_value (w_value)
   );

   assign bus.grant   = r_grant;
   assign bus.busy    = (r_state != StIdle);
   assign bus.done    = (r_state == StDone);
   assign bus.abort   = r_abort;
   assign bus.done_id = r_done_id;
   assign bus.value   = w_value;

endmodule

// File: tb/tb_counter_arb.sv
// Bench for counter_arb: directed scenarios plus random traffic against a cycle-level window model.
module tb_counter_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int ID = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fails  = 0;

   // Reference model: who owns the counter, where the window stands, pending pulses.
   int m_owner;
   int m_len;
   int m_value;
   int m_last;
   int m_id;
   bit m_done;
   bit m_abort;

   always #5 clk = ~clk;

   counter_arb_if #(.NREQ(N), .WIDTH(W), .IDW(ID)) bus ();

   counter_arb #(
      .NREQ (N),
      .WIDTH(W),
      .IDW  (ID)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_len(input int i, input int v);
      bus.len[i*W +: W] = W'(v);
   endtask

   // Apply the window rules to the model for one rising edge.
   task automatic model_edge();
      logic [N-1:0] rq;
      rq = bus.req;
      if (reset === 1'b0) begin
         m_owner = -1;
         m_len   = 0;
         m_value = 0;
         m_last  = N - 1;
         m_id    = 0;
         m_done  = 0;
         m_abort = 0;
      end else begin
         m_abort = 0;
         if (m_done) begin
            m_done  = 0;
            m_owner = -1;
         end else if (m_owner >= 0) begin
            if (!rq[m_owner]) begin
               m_abort = 1;
               m_owner = -1;
            end else if (m_value == m_len - 1) begin
               m_done = 1;
            end else begin
               m_value++;
            end
         end else if (rq != '0) begin
            for (int i = 1; i <= N; i++) begin
               int w;
               w = (m_last + i) % N;
               if (rq[w]) begin
                  m_owner = w;
                  break;
               end
            end
            m_last  = m_owner;
            m_len   = int'(bus.len[m_owner*W +: W]);
            m_value = 0;
            m_id    = m_owner;
            m_done  = (m_len == 0);
         end
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      check_eq("grant", bus.grant, g);
      check_eq("busy", bus.busy, m_owner >= 0);
      check_eq("value", bus.value, m_value);
      check_eq("done", bus.done, m_done);
      check_eq("abort", bus.abort, m_abort);
      if (m_done || m_abort) check_eq("done_id", bus.done_id, m_id);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      bus.req = '0;
      step();
      reset = 1'b1;
   endtask

   // Step until done or abort shows up; n returns the number of edges taken.
   task automatic wait_event(input string tag, input int budget, output int n);
      n = 0;
      while (!(bus.done === 1'b1 || bus.abort === 1'b1) && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, bus.done | bus.abort, 1);
   endtask

   task automatic wait_value(input string tag, input int v, input int budget);
      int n;
      n = 0;
      while (!(bus.busy === 1'b1 && bus.value == W'(v)) && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, bus.value, v);
   endtask

   initial begin
      int n;
      int ids[$];
      int exp_rr[5] = '{0, 1, 2, 3, 0};

      reset   = 1'b0;
      bus.req = '0;
      bus.len = '0;
      step();
      step();
      check_eq("rst_grant", bus.grant, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_value", bus.value, 0);
      check_eq("rst_done_id", bus.done_id, 0);
      reset = 1'b1;

      // Single request of length 3.
      bus.req = 4'b0001;
      set_len(0, 3);
      step();
      check_eq("single_grant", bus.grant, 4'b0001);
      check_eq("single_v0", bus.value, 0);
      step();
      check_eq("single_v1", bus.value, 1);
      step();
      check_eq("single_v2", bus.value, 2);
      step();
      check_eq("single_done", bus.done, 1);
      check_eq("single_id", bus.done_id, 0);
      bus.req = '0;
      step();
      check_eq("single_release", bus.grant, 0);

      // Round-robin with every requester held high.
      do_reset();
      for (int i = 0; i < N; i++) set_len(i, 2);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_event("rr_wait", 20, n);
         ids.push_back(int'(bus.done_id));
         step();
      end
      bus.req = '0;
      for (int k = 0; k < 5; k++) check_eq("rr_order", ids[k], exp_rr[k]);

      // Zero-length window goes straight to done.
      do_reset();
      bus.req = 4'b0100;
      set_len(2, 0);
      step();
      check_eq("zero_done", bus.done, 1);
      check_eq("zero_id", bus.done_id, 2);
      check_eq("zero_value", bus.value, 0);
      bus.req = '0;
      step();

      // Owner abandons mid-window while another request waits.
      do_reset();
      bus.req = 4'b0010;
      set_len(1, 10);
      wait_value("abandon_v4", 4, 20);
      bus.req = 4'b1000;
      set_len(3, 2);
      step();
      check_eq("abandon_abort", bus.abort, 1);
      check_eq("abandon_id", bus.done_id, 1);
      check_eq("abandon_grant", bus.grant, 0);
      check_eq("abandon_nodone", bus.done, 0);
      step();
      check_eq("abandon_next", bus.grant, 4'b1000);
      wait_event("abandon_wait", 20, n);
      check_eq("abandon_next_done", bus.done, 1);
      bus.req = '0;
      step();

      // Reset in the middle of a window.
      do_reset();
      bus.req = 4'b0001;
      set_len(0, 20);
      wait_value("midrst_v5", 5, 20);
      reset = 1'b0;
      step();
      check_eq("midrst_grant", bus.grant, 0);
      check_eq("midrst_value", bus.value, 0);
      check_eq("midrst_busy", bus.busy, 0);
      reset   = 1'b1;
      bus.req = 4'b1001;
      step();
      check_eq("midrst_first", bus.grant, 4'b0001);
      bus.req = '0;
      step();
      step();

      // Longest window; a length change after grant must be ignored.
      do_reset();
      bus.req = 4'b0001;
      set_len(0, 255);
      step();
      set_len(0, 2);
      wait_event("max_wait", 300, n);
      check_eq("max_cycles", n, 255);
      check_eq("max_value", bus.value, 254);
      check_eq("max_done", bus.done, 1);
      bus.req = '0;
      step();

      // Random traffic, including owner drops and occasional resets.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
         end
         if ($urandom_range(3) == 0) begin
            set_len(int'($urandom_range(N - 1)),
                    ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(5)));
         end
         reset = ($urandom_range(150) == 0) ? 1'b0 : 1'b1;
         step();
         check_eq("excl", bus.done & bus.abort, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
